// File: rtl/ethii_demux_if.sv
// Ethernet II stream bundle: parsed header (dest/src/type) plus 32-bit payload.
interface ethii_demux_if;
    logic [47:0] mac_dest;
    logic [47:0] mac_src;
    logic [15:0] mac_type;
    logic        mac_vld;
    logic        mac_rdy;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvld;
    logic        trdy;

    // Producer of header and payload; both readies come back from the consumer.
    modport master (
        output mac_dest, mac_src, mac_type, mac_vld, tdata, tkeep, tlast, tvld,
        input  mac_rdy, trdy
    );

    // Consumer of header and payload.
    modport slave (
        input  mac_dest, mac_src, mac_type, mac_vld, tdata, tkeep, tlast, tvld,
        output mac_rdy, trdy
    );
endinterface

// File: rtl/ethii_demux.sv
// Ethernet II receive demux: classifies each frame by EtherType and optional
// destination-MAC filter, then forwards it to the ARP or IPv4 port or drops it.
module ethii_demux #(
    parameter bit FILTER_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [47:0]        local_mac,
    ethii_demux_if.slave       rx,
    ethii_demux_if.master      arp,
    ethii_demux_if.master      ipv4,
    output logic [CNT_W-1:0]   drop_cnt
);
    localparam logic [15:0] TYPE_ARP  = 16'h0806;
    localparam logic [15:0] TYPE_IPV4 = 16'h0800;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {IDLE, PLD_ARP, PLD_IPV4, DROP} state_t;

    state_t state;
    state_t state_nxt;

    logic addr_ok;
    logic is_arp;
    logic is_ipv4;
    logic hdr_rdy;
    logic hdr_hs;
    logic pld_rdy;
    logic beat_hs;
    logic arp_reg_free;
    logic ipv4_reg_free;

    assign addr_ok = !FILTER_EN || (rx.mac_dest == local_mac) || (rx.mac_dest == MAC_BCAST);
    assign is_arp  = addr_ok && (rx.mac_type == TYPE_ARP);
    assign is_ipv4 = addr_ok && (rx.mac_type == TYPE_IPV4);

    // A new header is only taken once both header registers have drained.
    assign hdr_rdy = !reset && (state == IDLE) && !arp.mac_vld && !ipv4.mac_vld;
    assign hdr_hs  = rx.mac_vld && hdr_rdy;

    assign arp_reg_free  = !arp.tvld || arp.trdy;
    assign ipv4_reg_free = !ipv4.tvld || ipv4.trdy;
    assign beat_hs       = rx.tvld && pld_rdy;

    assign rx.mac_rdy = hdr_rdy;
    assign rx.trdy    = pld_rdy;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and payload ready for the active port.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        state_nxt = state;
        pld_rdy   = 1'b0;
        case (state)
            IDLE: begin
                if (hdr_hs) begin
                    if (is_arp) begin
                        state_nxt = PLD_ARP;
                    end else if (is_ipv4) begin
                        state_nxt = PLD_IPV4;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            PLD_ARP:  pld_rdy = arp_reg_free;
            PLD_IPV4: pld_rdy = ipv4_reg_free;
            DROP:     pld_rdy = 1'b1;
            default:  state_nxt = IDLE;
        endcase
        if (reset) begin
            pld_rdy = 1'b0;
        end
        // Payload is never accepted in IDLE, so this only fires in a payload state.
        if (rx.tvld && pld_rdy && rx.tlast) begin
            state_nxt = IDLE;
        end
    end

    // ARP header register: loaded at classification, held until taken downstream.
    always_ff @(posedge clk) begin
        // NOTE: only the valid flag is reset; header/data fields are don't-care while invalid.
        if (reset) begin
            arp.mac_vld <= 1'b0;
        end else if (hdr_hs && is_arp) begin
            arp.mac_vld  <= 1'b1;
            arp.mac_dest <= rx.mac_dest;
            arp.mac_src  <= rx.mac_src;
            arp.mac_type <= rx.mac_type;
        end else if (arp.mac_rdy) begin
            arp.mac_vld <= 1'b0;
        end
    end

    // IPv4 header register: loaded at classification, held until taken downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            ipv4.mac_vld <= 1'b0;
        end else if (hdr_hs && is_ipv4) begin
            ipv4.mac_vld  <= 1'b1;
            ipv4.mac_dest <= rx.mac_dest;
            ipv4.mac_src  <= rx.mac_src;
            ipv4.mac_type <= rx.mac_type;
        end else if (ipv4.mac_rdy) begin
            ipv4.mac_vld <= 1'b0;
        end
    end

    // ARP payload register: one beat of buffering, held stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            arp.tvld <= 1'b0;
        end else if ((state == PLD_ARP) && beat_hs) begin
            arp.tvld  <= 1'b1;
            arp.tdata <= rx.tdata;
            arp.tkeep <= rx.tkeep;
            arp.tlast <= rx.tlast;
        end else if (arp.trdy) begin
            arp.tvld <= 1'b0;
        end
    end

    // IPv4 payload register: one beat of buffering, held stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            ipv4.tvld <= 1'b0;
        end else if ((state == PLD_IPV4) && beat_hs) begin
            ipv4.tvld  <= 1'b1;
            ipv4.tdata <= rx.tdata;
            ipv4.tkeep <= rx.tkeep;
            ipv4.tlast <= rx.tlast;
        end else if (ipv4.trdy) begin
            ipv4.tvld <= 1'b0;
        end
    end

    // Dropped-frame counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (hdr_hs && !is_arp && !is_ipv4 && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ethii_demux.sv
// Directed bench for ethii_demux: frame table plus hand-written corner sequences.
// A second instance (no address filter, 2-bit counter) shadows the first.
module tb_ethii_demux;
    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_99;
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC_MAC   = 48'h0A_0B_0C_0D_0E_0F;
    localparam int          NVEC      = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] drop_cnt;
    logic [1:0]  drop_cnt2;

    ethii_demux_if rx();
    ethii_demux_if arp();
    ethii_demux_if ipv4();
    ethii_demux_if rx2();
    ethii_demux_if arp2();
    ethii_demux_if ipv4_2();

    ethii_demux #(.FILTER_EN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .local_mac(LOCAL_MAC),
        .rx(rx), .arp(arp), .ipv4(ipv4), .drop_cnt(drop_cnt)
    );

    ethii_demux #(.FILTER_EN(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .local_mac(LOCAL_MAC),
        .rx(rx2), .arp(arp2), .ipv4(ipv4_2), .drop_cnt(drop_cnt2)
    );

    // The shadow instance sees identical stimulus and downstream readies.
    assign rx2.mac_dest  = rx.mac_dest;
    assign rx2.mac_src   = rx.mac_src;
    assign rx2.mac_type  = rx.mac_type;
    assign rx2.mac_vld   = rx.mac_vld;
    assign rx2.tdata     = rx.tdata;
    assign rx2.tkeep     = rx.tkeep;
    assign rx2.tlast     = rx.tlast;
    assign rx2.tvld      = rx.tvld;
    assign arp2.mac_rdy  = arp.mac_rdy;
    assign arp2.trdy     = arp.trdy;
    assign ipv4_2.mac_rdy = ipv4.mac_rdy;
    assign ipv4_2.trdy    = ipv4.trdy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] dest;
        logic [15:0] mtype;
        int          beats;
        bit          toggle;
        int          exp_arp;
        int          exp_ipv4;
        int          exp_arp_hdr;
        int          exp_ipv4_hdr;
        int          exp_drop;
        int          exp_d2_ipv4;
        int          exp_d2_drop;
    } frame_vec_t;

    frame_vec_t vecs[NVEC];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor state (written only by the monitor) and frame context (written by the main flow).
    int          arp_beats = 0, ipv4_beats = 0, d2_beats = 0;
    int          arp_hdr_cyc = 0, ipv4_hdr_cyc = 0, arp_hdr_hs = 0, ipv4_hdr_hs = 0;
    int          data_err = 0, lat_err = 0, stall_err = 0, trdy_err = 0;
    logic [47:0] arp_hdr_dest, arp_hdr_src, ipv4_hdr_dest, ipv4_hdr_src;
    logic [15:0] arp_hdr_type, ipv4_hdr_type;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data;
    logic [3:0]  stall_keep;

    bit          mon_en = 1'b0, lat_chk = 1'b0, trdy_chk = 1'b0;
    int          arp_start = 0, ipv4_start = 0;
    logic [31:0] cur_base = '0;
    int          cur_beats = 0;
    int          in_edge[64];

    function automatic bit beat_ok(input logic [31:0] d, input logic [3:0] k, input logic l, input int idx);
        bit last;
        last = (idx == cur_beats - 1);
        return (d === cur_base + 32'(idx)) && (k === (last ? 4'h3 : 4'hF)) && (l === last);
    endfunction

    // Output monitor: sampled on the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin : mon
        int idx;
        if (mon_en) begin
            if (arp.mac_vld === 1'b1) begin
                arp_hdr_cyc++;
                if (arp.mac_rdy) begin
                    arp_hdr_hs++;
                    arp_hdr_dest = arp.mac_dest;
                    arp_hdr_src  = arp.mac_src;
                    arp_hdr_type = arp.mac_type;
                end
            end
            if (ipv4.mac_vld === 1'b1) begin
                ipv4_hdr_cyc++;
                if (ipv4.mac_rdy) begin
                    ipv4_hdr_hs++;
                    ipv4_hdr_dest = ipv4.mac_dest;
                    ipv4_hdr_src  = ipv4.mac_src;
                    ipv4_hdr_type = ipv4.mac_type;
                end
            end
            if (arp.tvld === 1'b1 && arp.trdy) begin
                idx = arp_beats - arp_start;
                if (!beat_ok(arp.tdata, arp.tkeep, arp.tlast, idx)) data_err++;
                if (lat_chk && idx < 64 && (cyc + 1 - in_edge[idx]) != 1) lat_err++;
                arp_beats++;
            end
            if (ipv4.tvld === 1'b1 && ipv4.trdy) begin
                idx = ipv4_beats - ipv4_start;
                if (!beat_ok(ipv4.tdata, ipv4.tkeep, ipv4.tlast, idx)) data_err++;
                if (lat_chk && idx < 64 && (cyc + 1 - in_edge[idx]) != 1) lat_err++;
                ipv4_beats++;
            end
            if (stall_prev && (ipv4.tvld !== 1'b1 || ipv4.tdata !== stall_data || ipv4.tkeep !== stall_keep))
                stall_err++;
            stall_prev = (ipv4.tvld === 1'b1) && !ipv4.trdy;
            stall_data = ipv4.tdata;
            stall_keep = ipv4.tkeep;
            if (trdy_chk && rx.tvld && (rx.trdy !== (!ipv4.tvld || ipv4.trdy))) trdy_err++;
            if (ipv4_2.tvld === 1'b1 && ipv4_2.trdy) d2_beats++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_hdr(input logic [47:0] dest, input logic [15:0] mtype, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        rx.mac_dest = dest;
        rx.mac_src  = SRC_MAC;
        rx.mac_type = mtype;
        rx.mac_vld  = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = (rx.mac_rdy === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        rx.mac_vld = 1'b0;
    endtask

    // Sends beats 0..n-1 of a frame of 'total' beats; tlast only on beat total-1.
    task automatic send_beats(input int n, input int total, input bit toggle, output int ncyc, output bit ok);
        bit got;
        int t;
        ncyc = 0;
        ok   = 1'b1;
        for (int i = 0; i < n; i++) begin
            rx.tdata = cur_base + 32'(i);
            rx.tkeep = (i == total - 1) ? 4'h3 : 4'hF;
            rx.tlast = (i == total - 1);
            rx.tvld  = 1'b1;
            got = 1'b0;
            t   = 0;
            while (!got && t < 200) begin
                @(negedge clk);
                got = (rx.trdy === 1'b1);
                if (got) in_edge[i] = cyc + 1;
                @(posedge clk);
                #1;
                if (toggle) ipv4.trdy = ~ipv4.trdy;
                t++;
                ncyc++;
            end
            if (!got) ok = 1'b0;
        end
        rx.tvld  = 1'b0;
        rx.tlast = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          ncyc, hold_err;
        int          ahc0, ihc0, ahs0, ihs0, d20, de0, le0, se0, te0;
        frame_vec_t  fv;

        //            dest       type      n  tgl arp ip4 ahd ihd drp d2ip d2dr
        vecs[0] = '{BCAST,     16'h0806,  7, 0,  7,  0,  1,  0,  0,  0,   0};
        vecs[1] = '{LOCAL_MAC, 16'h0800, 12, 1,  0, 12,  0,  1,  0, 12,   0};
        vecs[2] = '{LOCAL_MAC, 16'h86DD,  5, 0,  0,  0,  0,  0,  1,  0,   1};
        vecs[3] = '{OTHER_MAC, 16'h0800,  4, 0,  0,  0,  0,  0,  2,  4,   1};
        vecs[4] = '{BCAST,     16'h0806,  1, 0,  1,  0,  1,  0,  2,  0,   1};
        vecs[5] = '{LOCAL_MAC, 16'h88CC,  1, 0,  0,  0,  0,  0,  3,  0,   2};
        vecs[6] = '{BCAST,     16'h88CC,  2, 0,  0,  0,  0,  0,  4,  0,   3};
        vecs[7] = '{LOCAL_MAC, 16'h86DD,  1, 0,  0,  0,  0,  0,  5,  0,   3};

        reset       = 1'b1;
        rx.mac_dest = '0;
        rx.mac_src  = '0;
        rx.mac_type = '0;
        rx.mac_vld  = 1'b0;
        rx.tdata    = '0;
        rx.tkeep    = '0;
        rx.tlast    = 1'b0;
        rx.tvld     = 1'b0;
        arp.mac_rdy  = 1'b1;
        arp.trdy     = 1'b1;
        ipv4.mac_rdy = 1'b1;
        ipv4.trdy    = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst hdr_rdy", rx.mac_rdy, 0);
        check("rst user_trdy", rx.trdy, 0);
        check("rst arp_mac_vld", arp.mac_vld, 0);
        check("rst ipv4_tvld", ipv4.tvld, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle hdr_rdy", rx.mac_rdy, 1);
        check("idle user_trdy", rx.trdy, 0);
        check("idle drop_cnt", drop_cnt, 0);
        check("idle vld", {arp.mac_vld, ipv4.mac_vld, arp.tvld, ipv4.tvld}, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Frame table.
        for (int v = 0; v < NVEC; v++) begin
            fv = vecs[v];
            arp_start = arp_beats; ipv4_start = ipv4_beats; d20 = d2_beats;
            ahc0 = arp_hdr_cyc; ihc0 = ipv4_hdr_cyc;
            de0 = data_err; le0 = lat_err; se0 = stall_err; te0 = trdy_err;
            cur_base  = 32'hA000_0000 + 32'(v << 8);
            cur_beats = fv.beats;
            lat_chk   = !fv.toggle;
            send_hdr(fv.dest, fv.mtype, ok);
            check($sformatf("v%0d hdr_accept", v), ok, 1);
            trdy_chk = fv.toggle;
            send_beats(fv.beats, fv.beats, fv.toggle, ncyc, ok);
            trdy_chk  = 1'b0;
            ipv4.trdy = 1'b1;
            check($sformatf("v%0d beats_accept", v), ok, 1);
            repeat (4) @(posedge clk);
            #1;
            if (!fv.toggle) check($sformatf("v%0d input_cycles", v), ncyc, fv.beats);
            check($sformatf("v%0d arp_beats", v), arp_beats - arp_start, fv.exp_arp);
            check($sformatf("v%0d ipv4_beats", v), ipv4_beats - ipv4_start, fv.exp_ipv4);
            check($sformatf("v%0d arp_hdr_cycles", v), arp_hdr_cyc - ahc0, fv.exp_arp_hdr);
            check($sformatf("v%0d ipv4_hdr_cycles", v), ipv4_hdr_cyc - ihc0, fv.exp_ipv4_hdr);
            check($sformatf("v%0d drop_cnt", v), drop_cnt, fv.exp_drop);
            check($sformatf("v%0d nofilt_ipv4_beats", v), d2_beats - d20, fv.exp_d2_ipv4);
            check($sformatf("v%0d nofilt_drop_cnt", v), drop_cnt2, fv.exp_d2_drop);
            check($sformatf("v%0d beat_errors", v), data_err - de0, 0);
            check($sformatf("v%0d latency_errors", v), lat_err - le0, 0);
            check($sformatf("v%0d stall_errors", v), stall_err - se0, 0);
            check($sformatf("v%0d user_trdy_errors", v), trdy_err - te0, 0);
            if (fv.exp_arp_hdr != 0) begin
                check($sformatf("v%0d arp_hdr_type", v), arp_hdr_type, fv.mtype);
                check($sformatf("v%0d arp_hdr_dest", v), arp_hdr_dest, fv.dest);
                check($sformatf("v%0d arp_hdr_src", v), arp_hdr_src, SRC_MAC);
            end
            if (fv.exp_ipv4_hdr != 0) begin
                check($sformatf("v%0d ipv4_hdr_type", v), ipv4_hdr_type, fv.mtype);
                check($sformatf("v%0d ipv4_hdr_dest", v), ipv4_hdr_dest, fv.dest);
            end
        end

        // ARP header held downstream blocks the next (IPv4) header.
        arp_start = arp_beats; ipv4_start = ipv4_beats;
        ahs0 = arp_hdr_hs; ihs0 = ipv4_hdr_hs; de0 = data_err;
        cur_base  = 32'hB000_0000;
        cur_beats = 3;
        lat_chk   = 1'b0;
        arp.mac_rdy = 1'b0;
        send_hdr(BCAST, 16'h0806, ok);
        check("b2b arp hdr_accept", ok, 1);
        send_beats(3, 3, 1'b0, ncyc, ok);
        rx.mac_dest = LOCAL_MAC;
        rx.mac_type = 16'h0800;
        rx.mac_vld  = 1'b1;
        hold_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx.mac_rdy !== 1'b0 || arp.mac_vld !== 1'b1) hold_err++;
        end
        check("b2b hold_errors", hold_err, 0);
        @(posedge clk);
        #1;
        arp.mac_rdy = 1'b1;
        send_hdr(LOCAL_MAC, 16'h0800, ok);
        check("b2b ipv4 hdr_accept", ok, 1);
        send_beats(3, 3, 1'b0, ncyc, ok);
        repeat (4) @(posedge clk);
        #1;
        check("b2b arp_hdr_hs", arp_hdr_hs - ahs0, 1);
        check("b2b ipv4_hdr_hs", ipv4_hdr_hs - ihs0, 1);
        check("b2b ipv4_hdr_type", ipv4_hdr_type, 16'h0800);
        check("b2b arp_beats", arp_beats - arp_start, 3);
        check("b2b ipv4_beats", ipv4_beats - ipv4_start, 3);
        check("b2b beat_errors", data_err - de0, 0);
        check("b2b drop_cnt", drop_cnt, 5);

        // Reset on beat 3 of a 6-beat IPv4 frame.
        ipv4_start = ipv4_beats; de0 = data_err;
        cur_base  = 32'hC000_0000;
        cur_beats = 6;
        ipv4.mac_rdy = 1'b0;
        send_hdr(LOCAL_MAC, 16'h0800, ok);
        check("rstmid hdr_accept", ok, 1);
        send_beats(2, 6, 1'b0, ncyc, ok);
        rx.tdata = cur_base + 32'd2;
        rx.tkeep = 4'hF;
        rx.tvld  = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        check("rstmid pre ipv4_mac_vld", ipv4.mac_vld, 1);
        check("rstmid pre ipv4_tvld", ipv4.tvld, 1);
        check("rstmid hdr_rdy in reset", rx.mac_rdy, 0);
        check("rstmid user_trdy in reset", rx.trdy, 0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        rx.tvld = 1'b0;
        @(negedge clk);
        check("rstmid vld", {arp.mac_vld, ipv4.mac_vld, arp.tvld, ipv4.tvld}, 0);
        check("rstmid drop_cnt", drop_cnt, 0);
        check("rstmid idle hdr_rdy", rx.mac_rdy, 1);
        check("rstmid ipv4_beats", ipv4_beats - ipv4_start, 2);
        check("rstmid beat_errors", data_err - de0, 0);
        @(posedge clk);
        #1;
        ipv4.mac_rdy = 1'b1;

        // Fresh ARP frame after the aborted one.
        arp_start = arp_beats; ipv4_start = ipv4_beats; ahs0 = arp_hdr_hs;
        de0 = data_err; le0 = lat_err;
        cur_base  = 32'hD000_0000;
        cur_beats = 4;
        lat_chk   = 1'b1;
        send_hdr(BCAST, 16'h0806, ok);
        check("post hdr_accept", ok, 1);
        send_beats(4, 4, 1'b0, ncyc, ok);
        repeat (4) @(posedge clk);
        #1;
        check("post input_cycles", ncyc, 4);
        check("post arp_hdr_hs", arp_hdr_hs - ahs0, 1);
        check("post arp_beats", arp_beats - arp_start, 4);
        check("post ipv4_beats", ipv4_beats - ipv4_start, 0);
        check("post beat_errors", data_err - de0, 0);
        check("post latency_errors", lat_err - le0, 0);
        check("post drop_cnt", drop_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
